tracker: RTL and testbench
==========================

Name: tracker

Overview:
- Sink end of the valid/ready stream produced by the generator; consumes beats from the upstream `up_*` interface.
- Applies a programmable backpressure pattern on `up_ready`.
- Checks every accepted beat against an expected arithmetic sequence.
- Exposes beat/error counters, first-error capture and a completion flag for the testbench/monitor.

Parameters:
- DW, 16, data width.
- DELAY, 0, `up_ready` low cycles inserted after each accepted beat (0 = full throughput).
- START, 0, expected value of the first beat.
- STEP, 1, expected increment between beats, modulo 2^DW.
- NUM, 0, beats to accept before `done` (0 = unbounded).
- RESYNC, 1, 1: after a mismatch, expected = received + STEP; 0: expected = expected + STEP regardless.

Ports:
- clk  in  1  clock; single clock domain, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  start/continue accepting beats.
- up_valid  in  1  upstream beat valid.
- up_data  in  DW  upstream beat data.
- up_ready  out  1  sink ready; driven directly from a flop, no combinational path from any input.
- rcv_cnt  out  32  accepted beats, wraps at 2^32.
- err_cnt  out  16  mismatching beats, saturates at 16'hFFFF.
- err_any  out  1  sticky: at least one mismatch seen.
- err_exp  out  DW  expected value at first mismatch.
- err_got  out  DW  received value at first mismatch.
- done  out  1  sticky: NUM beats accepted (NUM>0 only).

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state IDLE; `up_ready`=0.
  - `rcv_cnt`=0, `err_cnt`=0, `err_any`=0, `err_exp`=0, `err_got`=0, `done`=0.
  - expected=START, stall counter=0.
  - Outputs take reset values immediately, without waiting for a clock edge. Reset mid-stall or mid-transfer discards all progress.
- Handshake: a beat is accepted on a rising edge where `up_valid`=1 and `up_ready`=1. No other condition affects acceptance.
- `up_valid` low while `up_ready`=1: no count and no state change.
- States:
  - IDLE: `up_ready`=0. Goes to ACCEPT when `enable`=1.
  - ACCEPT: `up_ready`=1.
    - On handshake: if NUM≠0 and `rcv_cnt`+1==NUM, go to DONE; else if DELAY>0, load stall counter with DELAY and go to STALL; else stay.
    - No handshake and `enable`=0: go to IDLE.
    - A handshake in the same cycle `enable` falls is still accepted and counted; the next state is then IDLE unless DONE/STALL applies.
  - STALL: `up_ready`=0; decrement counter each cycle. At 1, go to ACCEPT if `enable`=1, else IDLE. `enable` is ignored while the count runs.
  - DONE: `up_ready`=0, `done`=1. Stays until reset.
- `up_ready` pattern:
  - DELAY=0: `up_ready` stays 1 across consecutive beats.
  - DELAY=D: exactly D low cycles after each beat.
- Check, on each handshake:
  - `rcv_cnt`++.
  - Match (`up_data`==expected): expected += STEP, mod 2^DW.
  - Mismatch:
    - `err_cnt`++, saturating.
    - If `err_any`=0: capture `err_exp`/`err_got` and set `err_any`.
    - Advance expected according to RESYNC.
- Counters and flags update on the clock edge of the handshake and are visible the following cycle. `done` asserts the cycle after the NUM-th handshake.

Decomposition:
- Shared package/include `tracker_pkg`:
  - state encodings IDLE/ACCEPT/STALL/DONE (2 bits);
  - CNT_W=32, ERR_W=16;
  - stall-counter width = clog2(DELAY+1), minimum 1.
- One natural sub-module, `tracker_checker`: expected-value register, compare, RESYNC logic, `err_*` capture, `err_cnt` saturation.
- The top level holds the FSM, stall counter and `rcv_cnt`.

Test Plan:
- DELAY=0, NUM=8, START=0, `enable`=1, source drives 0..7 with `up_valid` constantly 1 → 8 handshakes on 8 consecutive edges; `rcv_cnt`=8, `err_cnt`=0; `done`=1 and `up_ready`=0 from the cycle after the 8th beat.
- DELAY=2, `up_valid` constantly 1, data 0,1,2 → `up_ready` pattern 1,0,0,1,0,0,1; 3 beats accepted in 7 cycles; no errors.
- RESYNC=1, data 0,1,5,6,7 → `err_cnt`=1, `err_exp`=2, `err_got`=5. Same stimulus with RESYNC=0 → `err_cnt`=3, `err_exp`=2, `err_got`=5, `err_any`=1.
- DW=4, START=14, STEP=1, data 14,15,0,1 → wrap-around accepted, `err_cnt`=0, `rcv_cnt`=4. Error-saturation run (70000 mismatching beats) → `err_cnt` holds at 16'hFFFF.
- `up_valid` toggled 1,0,0,1 during ACCEPT → only 2 beats counted, `up_ready` stays 1. `enable` dropped in the same cycle as a handshake → beat counted, next cycle IDLE with `up_ready`=0. `enable` reasserted → ACCEPT resumes with expected continuing.
- DELAY=3, `rst` pulsed low asynchronously (between clock edges) during STALL after 5 beats → `up_ready`, `rcv_cnt` and `err_*` go to 0 before the next edge. After release with `enable`=1 → expected=START again; a beat of value START is accepted without error.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types and sizing helpers for the stream tracker (sink/checker).
package tracker_pkg;

    // Sink FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        STALL  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 32;
    localparam int ERR_W = 16;

    // Stall counter must hold DELAY; keep at least one bit so DELAY=0 still elaborates
    function automatic int stall_w(input int delay);
        int w;
        w = $clog2(delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tracker_checker.sv
// Expected-sequence checker: tracks the next expected value, compares each
// accepted beat, counts mismatches (saturating) and captures the first one.
module tracker_checker
    import tracker_pkg::*;
#(
    parameter int DW     = 16,
    parameter int START  = 0,
    parameter int STEP   = 1,
    parameter int RESYNC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic [DW-1:0]    data,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_any,
    output logic [DW-1:0]    err_exp,
    output logic [DW-1:0]    err_got
);

    localparam logic [DW-1:0] START_V = DW'(START);
    localparam logic [DW-1:0] STEP_V  = DW'(STEP);

    logic [DW-1:0] expected;
    logic          match;

    // Error counter sticks at all-ones instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    assign match = (data == expected);

    // Advance expected value and record mismatches on every accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected <= START_V;
            err_cnt  <= '0;
            err_any  <= 1'b0;
            err_exp  <= '0;
            err_got  <= '0;
        end else if (hs) begin
            if (match) begin
                expected <= expected + STEP_V;
            end else begin
                err_cnt <= sat_inc(err_cnt);
                err_any <= 1'b1;
                if (!err_any) begin
                    err_exp <= expected;
                    err_got <= data;
                end
                // Resync follows the received stream; otherwise keep the original schedule
                expected <= (RESYNC != 0) ? (data + STEP_V) : (expected + STEP_V);
            end
        end
    end

endmodule

// File: rtl/tracker.sv
// Stream sink: applies a programmable up_ready pattern, counts accepted
// beats and hands each beat to the sequence checker.
module tracker
    import tracker_pkg::*;
#(
    parameter int DW     = 16,
    parameter int DELAY  = 0,
    parameter int START  = 0,
    parameter int STEP   = 1,
    parameter int NUM    = 0,
    parameter int RESYNC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_valid,
    input  logic [DW-1:0]    up_data,
    output logic             up_ready,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_any,
    output logic [DW-1:0]    err_exp,
    output logic [DW-1:0]    err_got,
    output logic             done
);

    localparam int               SW      = stall_w(DELAY);
    localparam logic [SW-1:0]    DELAY_V = SW'(DELAY);
    localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM);

    state_t        state, next_state;
    logic [SW-1:0] stall_cnt, stall_nxt;
    logic          hs;
    logic          last_beat;

    assign hs        = up_valid & up_ready;
    assign last_beat = (NUM != 0) && ((rcv_cnt + CNT_W'(1)) == NUM_V);

    // Next-state and stall-counter logic
    always_comb begin
        next_state = state;
        stall_nxt  = stall_cnt;
        case (state)
            IDLE: begin
                if (enable) next_state = ACCEPT;
            end
            ACCEPT: begin
                if (hs) begin
                    if (last_beat) begin
                        next_state = DONE;
                    end else if (DELAY > 0) begin
                        next_state = STALL;
                        stall_nxt  = DELAY_V;
                    end else if (!enable) begin
                        next_state = IDLE;
                    end
                end else if (!enable) begin
                    next_state = IDLE;
                end
            end
            STALL: begin
                if (stall_cnt <= SW'(1)) begin
                    next_state = enable ? ACCEPT : IDLE;
                    stall_nxt  = '0;
                end else begin
                    stall_nxt  = stall_cnt - SW'(1);
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; up_ready and done are registered so no input reaches them combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stall_cnt <= '0;
            up_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            stall_cnt <= stall_nxt;
            up_ready  <= (next_state == ACCEPT);
            done      <= (next_state == DONE);
        end
    end

    // Accepted-beat counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcv_cnt <= '0;
        end else if (hs) begin
            rcv_cnt <= rcv_cnt + CNT_W'(1);
        end
    end

    tracker_checker #(
        .DW     (DW),
        .START  (START),
        .STEP   (STEP),
        .RESYNC (RESYNC)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
        .data    (up_data),
        .err_cnt (err_cnt),
        .err_any (err_any),
        .err_exp (err_exp),
        .err_got (err_got)
    );

endmodule

// File: tb/tb_tracker.sv
// Directed bench for tracker: four instances cover throughput, backpressure,
// resync modes, wrap/saturation and asynchronous reset.
module tb_tracker;

    logic clk;
    logic rst;

    // Instance A: DELAY=0, NUM=8, RESYNC=1
    logic        en_a, vld_a, rdy_a, eany_a, done_a;
    logic [15:0] dat_a, ecnt_a, eexp_a, egot_a;
    logic [31:0] rcv_a;
    // Instance B: DELAY=2, NUM=0, RESYNC=0
    logic        en_b, vld_b, rdy_b, eany_b, done_b;
    logic [15:0] dat_b, ecnt_b, eexp_b, egot_b;
    logic [31:0] rcv_b;
    // Instance C: DW=4, START=14, NUM=0, RESYNC=1
    logic        en_c, vld_c, rdy_c, eany_c, done_c;
    logic [3:0]  dat_c, eexp_c, egot_c;
    logic [15:0] ecnt_c;
    logic [31:0] rcv_c;
    // Instance D: DELAY=3, NUM=0, RESYNC=1
    logic        en_d, vld_d, rdy_d, eany_d, done_d;
    logic [15:0] dat_d, ecnt_d, eexp_d, egot_d;
    logic [31:0] rcv_d;

    int n_cmp = 0;
    int n_mis = 0;
    int vals[$];

    tracker #(.DW(16), .DELAY(0), .START(0), .STEP(1), .NUM(8), .RESYNC(1)) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .up_valid(vld_a), .up_data(dat_a),
        .up_ready(rdy_a), .rcv_cnt(rcv_a), .err_cnt(ecnt_a), .err_any(eany_a),
        .err_exp(eexp_a), .err_got(egot_a), .done(done_a));

    tracker #(.DW(16), .DELAY(2), .START(0), .STEP(1), .NUM(0), .RESYNC(0)) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .up_valid(vld_b), .up_data(dat_b),
        .up_ready(rdy_b), .rcv_cnt(rcv_b), .err_cnt(ecnt_b), .err_any(eany_b),
        .err_exp(eexp_b), .err_got(egot_b), .done(done_b));

    tracker #(.DW(4), .DELAY(0), .START(14), .STEP(1), .NUM(0), .RESYNC(1)) u_c (
        .clk(clk), .rst(rst), .enable(en_c), .up_valid(vld_c), .up_data(dat_c),
        .up_ready(rdy_c), .rcv_cnt(rcv_c), .err_cnt(ecnt_c), .err_any(eany_c),
        .err_exp(eexp_c), .err_got(egot_c), .done(done_c));

    tracker #(.DW(16), .DELAY(3), .START(0), .STEP(1), .NUM(0), .RESYNC(1)) u_d (
        .clk(clk), .rst(rst), .enable(en_d), .up_valid(vld_d), .up_data(dat_d),
        .up_ready(rdy_d), .rcv_cnt(rcv_d), .err_cnt(ecnt_d), .err_any(eany_d),
        .err_exp(eexp_d), .err_got(egot_d), .done(done_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_a = 0; vld_a = 0; dat_a = '0;
        en_b = 0; vld_b = 0; dat_b = '0;
        en_c = 0; vld_c = 0; dat_c = '0;
        en_d = 0; vld_d = 0; dat_d = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Present vals[] one by one on the selected instance, advancing on each handshake
    task automatic send(input int which, input int budget);
        int   idx;
        logic r;
        idx = 0;
        r   = 1'b0;
        for (int c = 0; c < budget && idx < vals.size(); c++) begin
            case (which)
                0: begin vld_a = 1; dat_a = 16'(vals[idx]); r = rdy_a; end
                1: begin vld_b = 1; dat_b = 16'(vals[idx]); r = rdy_b; end
                2: begin vld_c = 1; dat_c = 4'(vals[idx]);  r = rdy_c; end
                default: begin vld_d = 1; dat_d = 16'(vals[idx]); r = rdy_d; end
            endcase
            step();
            if (r) idx++;
        end
        vld_a = 0; vld_b = 0; vld_c = 0; vld_d = 0;
        check_eq($sformatf("send%0d_beats", which), 32'(idx), 32'(vals.size()));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat[7];
        logic hs;

        idle_inputs();
        rst = 1'b0;
        step();
        step();

        // Reset values
        check_eq("rst_ready",   rdy_a,  0);
        check_eq("rst_rcv",     rcv_a,  0);
        check_eq("rst_errcnt",  ecnt_a, 0);
        check_eq("rst_errany",  eany_a, 0);
        check_eq("rst_errexp",  eexp_a, 0);
        check_eq("rst_errgot",  egot_a, 0);
        check_eq("rst_done",    done_a, 0);
        rst = 1'b1;

        // Full throughput, NUM=8
        en_a = 1; vld_a = 1; dat_a = 0;
        step();
        check_eq("a_ready_on", rdy_a, 1);
        for (int i = 0; i < 8; i++) begin
            dat_a = 16'(i);
            check_eq($sformatf("a_rdy_beat%0d", i), rdy_a, 1);
            step();
        end
        check_eq("a_done",     done_a, 1);
        check_eq("a_rdy_done", rdy_a,  0);
        check_eq("a_rcv8",     rcv_a,  8);
        check_eq("a_err0",     ecnt_a, 0);
        step();
        step();
        check_eq("a_rcv_hold",  rcv_a,  8);
        check_eq("a_done_hold", done_a, 1);
        vld_a = 0;

        // RESYNC=1 with a jump in the stream
        do_reset();
        en_a = 1;
        vals = '{0, 1, 5, 6, 7};
        send(0, 20);
        check_eq("r1_errcnt", ecnt_a, 1);
        check_eq("r1_errexp", eexp_a, 2);
        check_eq("r1_errgot", egot_a, 5);
        check_eq("r1_errany", eany_a, 1);
        check_eq("r1_rcv",    rcv_a,  5);

        // up_valid gaps, then enable falling with a handshake
        do_reset();
        en_a = 1;
        step();
        vld_a = 1; dat_a = 0;  check_eq("vt_rdy0", rdy_a, 1); step();
        vld_a = 0; dat_a = 9;  check_eq("vt_rdy1", rdy_a, 1); step();
        vld_a = 0; dat_a = 9;  check_eq("vt_rdy2", rdy_a, 1); step();
        vld_a = 1; dat_a = 1;  check_eq("vt_rdy3", rdy_a, 1); step();
        check_eq("vt_rcv2", rcv_a,  2);
        check_eq("vt_err0", ecnt_a, 0);
        vld_a = 1; dat_a = 2; en_a = 0;
        check_eq("en_rdy_pre", rdy_a, 1);
        step();
        check_eq("en_rcv3",     rcv_a, 3);
        check_eq("en_rdy_idle", rdy_a, 0);
        dat_a = 3;
        step();
        check_eq("en_rcv_idle", rcv_a, 3);
        en_a = 1;
        step();
        check_eq("en_rdy_back", rdy_a, 1);
        step();
        vld_a = 0;
        check_eq("en_rcv4", rcv_a,  4);
        check_eq("en_err0", ecnt_a, 0);

        // DELAY=2 backpressure pattern
        do_reset();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        en_b = 1; vld_b = 1; dat_b = 0;
        step();
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("b_pat%0d", i), rdy_b, pat[i]);
            hs = rdy_b;
            step();
            if (hs) dat_b = dat_b + 16'd1;
        end
        vld_b = 0;
        check_eq("b_rcv3", rcv_b,  3);
        check_eq("b_err0", ecnt_b, 0);

        // RESYNC=0 with the same jump
        do_reset();
        en_b = 1;
        vals = '{0, 1, 5, 6, 7};
        send(1, 60);
        check_eq("r0_errcnt", ecnt_b, 3);
        check_eq("r0_errexp", eexp_b, 2);
        check_eq("r0_errgot", egot_b, 5);
        check_eq("r0_errany", eany_b, 1);
        check_eq("r0_rcv",    rcv_b,  5);

        // DW=4 wrap-around, then error saturation
        do_reset();
        en_c = 1;
        vals = '{14, 15, 0, 1};
        send(2, 20);
        check_eq("w_rcv4",  rcv_c,  4);
        check_eq("w_err0",  ecnt_c, 0);
        check_eq("w_any0",  eany_c, 0);
        vld_c = 1; dat_c = 0;
        repeat (65534) step();
        check_eq("sat_fffe",   ecnt_c, 16'hFFFE);
        check_eq("sat_errexp", eexp_c, 2);
        check_eq("sat_errgot", egot_c, 0);
        step();
        check_eq("sat_ffff", ecnt_c, 16'hFFFF);
        repeat (4465) step();
        vld_c = 0;
        check_eq("sat_hold", ecnt_c, 16'hFFFF);
        check_eq("sat_rcv",  rcv_c,  70004);

        // Asynchronous reset during a DELAY=3 stall
        do_reset();
        en_d = 1;
        vals = '{0, 1, 2, 3, 9};
        send(3, 60);
        check_eq("d_rcv5",     rcv_d,  5);
        check_eq("d_errcnt",   ecnt_d, 1);
        check_eq("d_errexp",   eexp_d, 4);
        check_eq("d_errgot",   egot_d, 9);
        check_eq("d_rdy_stall", rdy_d, 0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_rdy",    rdy_d,  0);
        check_eq("ar_rcv",    rcv_d,  0);
        check_eq("ar_errcnt", ecnt_d, 0);
        check_eq("ar_errany", eany_d, 0);
        check_eq("ar_errexp", eexp_d, 0);
        check_eq("ar_errgot", egot_d, 0);
        step();
        rst = 1'b1;
        en_d = 1; vld_d = 1; dat_d = 0;
        check_eq("ar_rdy_idle", rdy_d, 0);
        step();
        check_eq("ar_rdy_on", rdy_d, 1);
        step();
        vld_d = 0;
        check_eq("ar_rcv1", rcv_d,  1);
        check_eq("ar_err0", ecnt_d, 0);
        check_eq("ar_any0", eany_d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
